// File: rtl/score_bcd_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : score_bcd_tracker
//  Description : Snake-game score / high-score tracker with saturation and a
//                multi-cycle double-dabble converter that turns the displayed
//                value (score while playing, high score when over) into BCD.
//  Revision    : 1.0 - initial release
// ============================================================================
module score_bcd_tracker #(
    parameter int WIDTH     = 10,
    parameter int DIGITS    = 3,
    parameter int PTS_W     = 4,
    parameter int MAX_SCORE = 999
) (
    input  logic                  clk,
    input  logic                  rst,
    input  logic                  good_coll,
    input  logic [PTS_W-1:0]      pts,
    input  logic                  bad_coll,
    input  logic                  start,
    input  logic                  clear_high,
    output logic [WIDTH-1:0]      score,
    output logic [WIDTH-1:0]      high_score,
    output logic                  game_over,
    output logic                  new_high,
    output logic [4*DIGITS-1:0]   bcd,
    output logic                  bcd_valid,
    output logic                  busy
);

    localparam int c_BCD_W = 4 * DIGITS;
    localparam int c_CNT_W = $clog2(WIDTH + 1);

    localparam logic [0:0] c_ST_PLAY = 1'b0;
    localparam logic [0:0] c_ST_OVER = 1'b1;

    localparam logic [1:0] c_CV_IDLE  = 2'd0;
    localparam logic [1:0] c_CV_SHIFT = 2'd1;
    localparam logic [1:0] c_CV_DONE  = 2'd2;

    localparam logic [WIDTH:0]       c_MAX_EXT   = (WIDTH + 1)'(MAX_SCORE);
    localparam logic [WIDTH-1:0]     c_MAX       = WIDTH'(MAX_SCORE);
    localparam logic [c_CNT_W-1:0]   c_LAST_STEP = c_CNT_W'(WIDTH - 1);

    // game state
    logic [0:0]          state_q,    state_d;
    logic [WIDTH-1:0]    score_q,    score_d;
    logic [WIDTH-1:0]    high_q,     high_d;
    logic                new_high_q, new_high_d;

    // converter state
    logic [1:0]          cv_q,       cv_d;
    logic [WIDTH-1:0]    shift_q,    shift_d;
    logic [c_BCD_W-1:0]  acc_q,      acc_d;
    logic [c_CNT_W-1:0]  cnt_q,      cnt_d;
    logic [WIDTH-1:0]    last_q,     last_d;
    logic [c_BCD_W-1:0]  bcd_q,      bcd_d;
    logic                valid_q,    valid_d;
    logic                busy_q,     busy_d;

    logic [WIDTH:0]      w_sum;
    logic [WIDTH-1:0]    w_disp;
    logic                w_over;
    logic [c_BCD_W-1:0]  w_acc_adj;

    // extra bit on the sum so an overflowing add still compares correctly
    assign w_sum = {1'b0, score_q} + (WIDTH + 1)'(pts);

    // state register for game and converter, asynchronously reset
    always_ff @(posedge clk or posedge rst) begin
        if (rst) begin
            state_q    <= c_ST_OVER;
            score_q    <= '0;
            high_q     <= '0;
            new_high_q <= 1'b0;
            cv_q       <= c_CV_IDLE;
            shift_q    <= '0;
            acc_q      <= '0;
            cnt_q      <= '0;
            last_q     <= '0;
            bcd_q      <= '0;
            valid_q    <= 1'b0;
            busy_q     <= 1'b0;
        end else begin
            state_q    <= state_d;
            score_q    <= score_d;
            high_q     <= high_d;
            new_high_q <= new_high_d;
            cv_q       <= cv_d;
            shift_q    <= shift_d;
            acc_q      <= acc_d;
            cnt_q      <= cnt_d;
            last_q     <= last_d;
            bcd_q      <= bcd_d;
            valid_q    <= valid_d;
            busy_q     <= busy_d;
        end
    end

    // game next-state: scoring, saturation, game over, high-score tracking
    always_comb begin
        state_d    = state_q;
        score_d    = score_q;
        high_d     = high_q;
        new_high_d = new_high_q;
        case (state_q)
            c_ST_OVER: begin
                if (start) begin
                    state_d    = c_ST_PLAY;
                    score_d    = '0;
                    new_high_d = 1'b0;
                end
                if (clear_high) begin
                    high_d     = '0;
                    new_high_d = 1'b0;
                end
            end
            default: begin
                if (bad_coll) begin
                    state_d = c_ST_OVER;
                end else if (good_coll) begin
                    if (w_sum >= c_MAX_EXT) begin
                        score_d = c_MAX;
                        state_d = c_ST_OVER;
                    end else begin
                        score_d = w_sum[WIDTH-1:0];
                    end
                    // only credited points can raise the high score, so a
                    // cleared high score is not refilled from a stale score
                    if (score_d > high_q) begin
                        high_d     = score_d;
                        new_high_d = 1'b1;
                    end
                end
            end
        endcase
    end

    // game outputs and the value routed to the converter
    always_comb begin
        w_over = (state_q == c_ST_OVER);
        w_disp = w_over ? high_q : score_q;
    end

    // add-3 correction applied to every BCD nibble before each shift
    always_comb begin
        w_acc_adj = acc_q;
        for (int i = 0; i < DIGITS; i++) begin
            if (acc_q[4*i +: 4] >= 4'd5) begin
                w_acc_adj[4*i +: 4] = acc_q[4*i +: 4] + 4'd3;
            end
        end
    end

    // converter next-state; DONE chains straight into a new conversion when
    // the display moved meanwhile so busy stays high while a change is pending
    always_comb begin
        cv_d    = cv_q;
        shift_d = shift_q;
        acc_d   = acc_q;
        cnt_d   = cnt_q;
        last_d  = last_q;
        bcd_d   = bcd_q;
        valid_d = 1'b0;
        busy_d  = busy_q;
        case (cv_q)
            c_CV_IDLE: begin
                if (w_disp != last_q) begin
                    shift_d = w_disp;
                    acc_d   = '0;
                    cnt_d   = '0;
                    last_d  = w_disp;
                    busy_d  = 1'b1;
                    cv_d    = c_CV_SHIFT;
                end
            end
            c_CV_SHIFT: begin
                acc_d   = {w_acc_adj[c_BCD_W-2:0], shift_q[WIDTH-1]};
                shift_d = {shift_q[WIDTH-2:0], 1'b0};
                cnt_d   = cnt_q + 1'b1;
                if (cnt_q == c_LAST_STEP) begin
                    cv_d = c_CV_DONE;
                end
            end
            c_CV_DONE: begin
                bcd_d   = acc_q;
                valid_d = 1'b1;
                busy_d  = 1'b0;
                cv_d    = c_CV_IDLE;
                if (w_disp != last_q) begin
                    shift_d = w_disp;
                    acc_d   = '0;
                    cnt_d   = '0;
                    last_d  = w_disp;
                    busy_d  = 1'b1;
                    cv_d    = c_CV_SHIFT;
                end
            end
            default: begin
                cv_d = c_CV_IDLE;
            end
        endcase
    end

    // drive ports from registered state
    always_comb begin
        score      = score_q;
        high_score = high_q;
        game_over  = w_over;
        new_high   = new_high_q;
        bcd        = bcd_q;
        bcd_valid  = valid_q;
        busy       = busy_q;
    end

endmodule
`default_nettype wire

// File: tb/tb_score_bcd_tracker.sv
`default_nettype none
// ============================================================================
//  Module      : tb_score_bcd_tracker
//  Description : Directed self-checking bench for score_bcd_tracker with an
//                expected-BCD queue popped on every bcd_valid.
//  Revision    : 1.0 - initial release
// ============================================================================
module tb_score_bcd_tracker;

    logic        clk = 1'b0;
    logic        rst;
    logic        good_coll, bad_coll, start, clear_high;
    logic [3:0]  pts;
    logic [9:0]  score, high_score;
    logic        game_over, new_high, bcd_valid, busy;
    logic [11:0] bcd;

    logic        g1, s1;
    logic [3:0]  p1;
    logic [9:0]  score1, high1;
    logic        over1, nh1, valid1, busy1;
    logic [11:0] bcd1;

    int          total = 0;
    int          bad   = 0;
    int          cyc   = 0;
    int          nvalid = 0;
    int          last_vcyc = 0;
    int          chg = 0;
    logic [11:0] exp_q[$];

    score_bcd_tracker dut (
        .clk(clk), .rst(rst), .good_coll(good_coll), .pts(pts),
        .bad_coll(bad_coll), .start(start), .clear_high(clear_high),
        .score(score), .high_score(high_score), .game_over(game_over),
        .new_high(new_high), .bcd(bcd), .bcd_valid(bcd_valid), .busy(busy)
    );

    score_bcd_tracker #(.MAX_SCORE(50)) dut50 (
        .clk(clk), .rst(rst), .good_coll(g1), .pts(p1),
        .bad_coll(1'b0), .start(s1), .clear_high(1'b0),
        .score(score1), .high_score(high1), .game_over(over1),
        .new_high(nh1), .bcd(bcd1), .bcd_valid(valid1), .busy(busy1)
    );

    always #5 clk = ~clk;

    always @(posedge clk) cyc <= cyc + 1;

    function automatic logic [11:0] to_bcd(input int v);
        return {4'(v / 100 % 10), 4'(v / 10 % 10), 4'(v % 10)};
    endfunction

    task automatic chk(input string tag, input logic [31:0] got, input logic [31:0] exp);
        total++;
        assert (got === exp) else begin
            bad++;
            $error("FAIL %s: observed=0x%0h expected=0x%0h", tag, got, exp);
        end
    endtask

    // one clock; sample at the falling edge and score any bcd_valid
    task automatic tick();
        @(negedge clk);
        if (bcd_valid === 1'b1) begin
            nvalid++;
            last_vcyc = cyc;
            total++;
            assert (exp_q.size() > 0) else begin
                bad++;
                $error("FAIL unexpected_valid: observed bcd=0x%0h expected no pulse", bcd);
            end
            if (exp_q.size() > 0) begin
                logic [11:0] e;
                e = exp_q.pop_front();
                total--;
                chk("bcd_on_valid", 32'(bcd), 32'(e));
            end
        end
    endtask

    task automatic wait_n(input int n);
        for (int i = 0; i < n; i++) tick();
    endtask

    task automatic settle();
        for (int i = 0; i < 60 && exp_q.size() > 0; i++) tick();
        if (exp_q.size() > 0) begin
            chk("settle_timeout", 32'(exp_q.size()), 32'd0);
            exp_q.delete();
        end
        wait_n(3);
    endtask

    task automatic pulse(input logic g, input logic [3:0] p, input logic b,
                         input logic s, input logic c);
        good_coll = g; pts = p; bad_coll = b; start = s; clear_high = c;
        tick();
        chg = cyc;
        good_coll = 1'b0; pts = 4'd0; bad_coll = 1'b0; start = 1'b0; clear_high = 1'b0;
    endtask

    task automatic pulse1(input logic g, input logic [3:0] p, input logic s);
        g1 = g; p1 = p; s1 = s;
        tick();
        g1 = 1'b0; p1 = 4'd0; s1 = 1'b0;
    endtask

    task automatic check_reset(input string tag);
        chk({tag, "_score"},  32'(score), 32'd0);
        chk({tag, "_high"},   32'(high_score), 32'd0);
        chk({tag, "_over"},   32'(game_over), 32'd1);
        chk({tag, "_nh"},     32'(new_high), 32'd0);
        chk({tag, "_bcd"},    32'(bcd), 32'd0);
        chk({tag, "_valid"},  32'(bcd_valid), 32'd0);
        chk({tag, "_busy"},   32'(busy), 32'd0);
    endtask

    initial begin
        int base;
        rst = 1'b1;
        good_coll = 1'b0; pts = 4'd0; bad_coll = 1'b0; start = 1'b0; clear_high = 1'b0;
        g1 = 1'b0; p1 = 4'd0; s1 = 1'b0;
        wait_n(3);
        rst = 1'b0;
        tick();
        check_reset("rst");
        wait_n(20);

        // new game, then seven 3-point pickups
        pulse(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("start_over", 32'(game_over), 32'd0);
        settle();
        for (int i = 1; i <= 7; i++) begin
            exp_q.push_back(to_bcd(3 * i));
            pulse(1'b1, 4'd3, 1'b0, 1'b0, 1'b0);
            settle();
            wait_n(14);
        end
        chk("latency21", 32'(last_vcyc - chg), 32'd12);
        chk("score21", 32'(score), 32'd21);
        chk("high21", 32'(high_score), 32'd21);
        chk("nh21", 32'(new_high), 32'd1);
        chk("bcd21", 32'(bcd), 32'h021);

        // game over: display switches to equal high score, no conversion
        pulse(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("bad_over", 32'(game_over), 32'd1);
        chk("bad_score", 32'(score), 32'd21);
        settle();

        // new game to 10, then simultaneous good+bad
        exp_q.push_back(to_bcd(0));
        pulse(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        chk("restart_nh", 32'(new_high), 32'd0);
        chk("restart_score", 32'(score), 32'd0);
        settle();
        exp_q.push_back(to_bcd(10));
        pulse(1'b1, 4'd10, 1'b0, 1'b0, 1'b0);
        settle();
        exp_q.push_back(to_bcd(21));
        pulse(1'b1, 4'd4, 1'b1, 1'b0, 1'b0);
        chk("gb_score", 32'(score), 32'd10);
        chk("gb_over", 32'(game_over), 32'd1);
        chk("gb_high", 32'(high_score), 32'd21);
        settle();

        // build high score 37, then clear it in OVER
        exp_q.push_back(to_bcd(0));
        pulse(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        settle();
        exp_q.push_back(to_bcd(15));
        pulse(1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
        settle();
        exp_q.push_back(to_bcd(30));
        pulse(1'b1, 4'd15, 1'b0, 1'b0, 1'b0);
        settle();
        exp_q.push_back(to_bcd(37));
        pulse(1'b1, 4'd7, 1'b0, 1'b0, 1'b0);
        settle();
        pulse(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        chk("high37", 32'(high_score), 32'd37);
        settle();
        exp_q.push_back(to_bcd(0));
        pulse(1'b0, 4'd0, 1'b0, 1'b0, 1'b1);
        chk("clr_high", 32'(high_score), 32'd0);
        chk("clr_nh", 32'(new_high), 32'd0);
        settle();
        chk("clr_latency", 32'(last_vcyc - chg), 32'd12);
        chk("clr_bcd", 32'(bcd), 32'h000);

        // start/clear_high ignored while playing
        pulse(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        settle();
        exp_q.push_back(to_bcd(5));
        pulse(1'b1, 4'd5, 1'b0, 1'b0, 1'b0);
        settle();
        pulse(1'b0, 4'd0, 1'b0, 1'b1, 1'b1);
        chk("play_clr_high", 32'(high_score), 32'd5);
        chk("play_clr_score", 32'(score), 32'd5);
        chk("play_clr_over", 32'(game_over), 32'd0);
        settle();

        // burst of three back-to-back pickups from a fresh game
        pulse(1'b0, 4'd0, 1'b1, 1'b0, 1'b0);
        settle();
        exp_q.push_back(to_bcd(0));
        pulse(1'b0, 4'd0, 1'b0, 1'b1, 1'b0);
        settle();
        exp_q.push_back(to_bcd(1));
        exp_q.push_back(to_bcd(3));
        base = nvalid;
        good_coll = 1'b1; pts = 4'd1;
        wait_n(3);
        good_coll = 1'b0; pts = 4'd0;
        for (int i = 0; i < 60; i++) begin
            tick();
            if (nvalid >= base + 2) break;
            chk("burst_busy", 32'(busy), 32'd1);
        end
        chk("burst_pulses", 32'(nvalid - base), 32'd2);
        chk("burst_bcd", 32'(bcd), 32'h003);
        chk("burst_score", 32'(score), 32'd3);
        settle();

        // reset five cycles into a conversion
        pulse(1'b1, 4'd2, 1'b0, 1'b0, 1'b0);
        wait_n(5);
        chk("pre_rst_busy", 32'(busy), 32'd1);
        rst = 1'b1;
        #1;
        chk("mid_rst_busy", 32'(busy), 32'd0);
        chk("mid_rst_bcd", 32'(bcd), 32'd0);
        chk("mid_rst_valid", 32'(bcd_valid), 32'd0);
        wait_n(3);
        rst = 1'b0;
        wait_n(20);
        check_reset("post_rst");
        chk("queue_empty", 32'(exp_q.size()), 32'd0);

        // saturation with MAX_SCORE=50
        pulse1(1'b0, 4'd0, 1'b1);
        pulse1(1'b1, 4'd15, 1'b0);
        pulse1(1'b1, 4'd15, 1'b0);
        pulse1(1'b1, 4'd15, 1'b0);
        pulse1(1'b1, 4'd3, 1'b0);
        chk("sat_score48", 32'(score1), 32'd48);
        chk("sat_over48", 32'(over1), 32'd0);
        pulse1(1'b1, 4'd5, 1'b0);
        chk("sat_score", 32'(score1), 32'd50);
        chk("sat_over", 32'(over1), 32'd1);
        pulse1(1'b1, 4'd5, 1'b0);
        chk("sat_ignored", 32'(score1), 32'd50);
        wait_n(20);
        chk("sat_bcd", 32'(bcd1), 32'h050);
        chk("sat_high", 32'(high1), 32'd50);

        $display("test done: total=%0d bad=%0d", total, bad);
        $finish;
    end

endmodule
`default_nettype wire

// File: doc/score_bcd_tracker.md
Name: score_bcd_tracker

Overview:
Parametrised score/high-score tracker for the snake game. It accumulates variable point values, saturates at a configurable maximum score and tracks a high score across games. A multi-cycle shift-add-3 (double-dabble) engine converts the displayed value to DIGITS packed BCD digits. It sits between the collision-event pulse detectors and the seven-segment digit multiplexer.

Parameters:
WIDTH, 10, bit width of score and high_score; MAX_SCORE < 2**WIDTH required
DIGITS, 3, number of BCD digits output; MAX_SCORE < 10**DIGITS required
PTS_W, 4, width of the per-event points input
MAX_SCORE, 999, saturation score; reaching it ends the game

Ports:
clk  input  1  clock
rst  input  1  reset, asynchronous, active-high
good_coll  input  1  single-cycle pulse: award pts
pts  input  PTS_W  points awarded on good_coll; 0 is legal (no change)
bad_coll  input  1  single-cycle pulse: game over
start  input  1  pulse: begin new game (honoured in OVER only)
clear_high  input  1  pulse: zero high score (honoured in OVER only)
score  output  WIDTH  current game score
high_score  output  WIDTH  best score since reset/clear
game_over  output  1  1 while FSM in OVER
new_high  output  1  sticky: high score raised during current/last game
bcd  output  4*DIGITS  packed BCD of display value, digit 0 in [3:0]
bcd_valid  output  1  one-cycle pulse when bcd updates
busy  output  1  converter running

Behaviour:
- Reset (async): FSM=OVER, score=0, high_score=0, new_high=0, bcd=0, bcd_valid=0, busy=0, last_conv=0 (bcd consistent with value 0; no conversion after reset).
- FSM PLAY: display value = score. FSM OVER: display value = high_score. game_over = (state==OVER), registered.
- OVER: start -> PLAY next edge, score<=0, new_high<=0. good_coll/bad_coll ignored. clear_high -> high_score<=0, new_high<=0. start and clear_high same cycle: both honoured.
- PLAY: start and clear_high ignored.
  - bad_coll (regardless of good_coll same cycle): -> OVER, score unchanged, no points credited.
  - good_coll without bad_coll: sum = score + pts, computed in WIDTH+1 bits. If sum >= MAX_SCORE: score<=MAX_SCORE, -> OVER same edge. Else score<=sum.
- High score: on any edge where next score > high_score, high_score<=next score and new_high<=1 (same edge as score update).
- Converter (states IDLE, SHIFT, DONE):
  - IDLE: if display value != last_conv, latch value into shift reg, clear BCD accumulator, last_conv<=value, busy<=1, -> SHIFT.
  - SHIFT: WIDTH edges; each edge adds 3 to every BCD nibble >=5, then shifts left 1 with binary MSB in.
  - DONE: bcd<=accumulator, bcd_valid=1 for this single cycle, busy<=0, -> IDLE.
  - Latency: display value changes at edge t -> bcd and bcd_valid at edge t+WIDTH+2 (12 cycles at default).
  - Changes while busy are not lost: compare in IDLE picks up latest value; intermediate values may be skipped; bcd always converges to the current display value.
  - FSM transition PLAY<->OVER changes display value and triggers conversion like any other change.
- Reset mid-conversion: all state returns to reset values immediately; no bcd_valid is emitted for the aborted conversion.
- bcd is held stable between bcd_valid pulses.

Test Plan:
- Reset, then start; good_coll pts=3 seven times, one pulse every 20 cycles -> score=21, high_score=21, new_high=1, bcd=0x021 with bcd_valid exactly 12 cycles after last score change.
- MAX_SCORE=50 override: score=48, good_coll pts=5 -> score=50, game_over=1 same edge; further good_coll ignored; bcd=0x050.
- PLAY at score=10: good_coll pts=4 and bad_coll same cycle -> score=10, game_over=1, high_score unchanged.
- Three good_coll pulses (pts=1) on consecutive cycles starting at score=0 -> final bcd=0x003, busy never drops while a mismatch is pending, at most 2 bcd_valid pulses.
- In OVER with high_score=37: clear_high -> high_score=0, bcd=0x000 after 12 cycles; start in PLAY with clear_high -> high_score unchanged.
- Assert rst at cycle 5 of a conversion -> busy=0, bcd=0, no bcd_valid; after release, all outputs at reset values.
